// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared state encoding, playfield geometry and ball-word
//                layout for the pong game controller and its display.
//  Revision    : 1.0
// ============================================================================
package pong_pkg;

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_serve    = 2'd1;
    localparam logic [1:0] c_st_play     = 2'd2;
    localparam logic [1:0] c_st_gameover = 2'd3;

    localparam int c_screen_w    = 640;
    localparam int c_screen_h    = 480;
    localparam int c_paddle_w    = 20;
    localparam int c_paddle_h    = 100;
    localparam int c_ball_sz     = 20;
    localparam int c_pl_x        = 100;
    localparam int c_pr_x        = 500;
    localparam int c_paddle_vel  = 10;
    localparam int c_ball_vel    = 3;
    localparam int c_win_score   = 7;
    localparam int c_serve_ticks = 32;

    // Ball word: {x[10:0], y[10:0], 10'd0}, read by the display side
    localparam int c_ball_x_msb = 31;
    localparam int c_ball_x_lsb = 21;
    localparam int c_ball_y_msb = 20;
    localparam int c_ball_y_lsb = 10;

    typedef logic [10:0]        coord_t;
    typedef logic signed [12:0] scoord_t;

    function automatic scoord_t clamp_s13(input scoord_t v, input scoord_t lo, input scoord_t hi);
        scoord_t r;
        r = v;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/pong_paddle_mover.sv
`default_nettype none
// ============================================================================
//  Module      : pong_paddle_mover
//  Description : One paddle's vertical position, driven by active-low
//                up/down buttons and saturated to the visible range.
//  Revision    : 1.0
// ============================================================================
module pong_paddle_mover
    import pong_pkg::*;
#(
    parameter int SCREEN_H   = c_screen_h,
    parameter int PADDLE_H   = c_paddle_h,
    parameter int PADDLE_VEL = c_paddle_vel
) (
    input  logic        slowclock,
    input  logic        iRST_n,
    input  logic        i_enable,
    input  logic        i_moveup_n,
    input  logic        i_movedown_n,
    output logic [11:0] o_ypos
);

    localparam scoord_t     c_y_min   = 13'sd0;
    localparam scoord_t     c_y_max   = scoord_t'(SCREEN_H - PADDLE_H);
    localparam scoord_t     c_vel     = scoord_t'(PADDLE_VEL);
    localparam logic [11:0] c_y_reset = 12'((SCREEN_H - PADDLE_H) / 2);

    logic [11:0] ypos_d;
    logic [11:0] ypos_q;
    scoord_t     w_y_s;
    scoord_t     w_y_next;

    // Opposing buttons cancel; the signed step lets saturation catch underflow
    always_comb begin
        w_y_s    = scoord_t'({1'b0, ypos_q});
        w_y_next = w_y_s;
        if (i_enable) begin
            if (!i_moveup_n && i_movedown_n) begin
                w_y_next = w_y_s - c_vel;
            end else if (i_moveup_n && !i_movedown_n) begin
                w_y_next = w_y_s + c_vel;
            end
        end
        ypos_d = 12'(clamp_s13(w_y_next, c_y_min, c_y_max));
    end

    always_ff @(posedge slowclock or negedge iRST_n) begin
        if (!iRST_n) begin
            ypos_q <= c_y_reset;
        end else begin
            ypos_q <= ypos_d;
        end
    end

    assign o_ypos = ypos_q;

endmodule : pong_paddle_mover
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pong_game_ctrl
//  Description : Pong game state machine: serve timing, ball motion with
//                wall/paddle bounces, scoring and two paddle movers.
//  Revision    : 1.0
// ============================================================================
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = c_screen_w,
    parameter int SCREEN_H    = c_screen_h,
    parameter int PADDLE_W    = c_paddle_w,
    parameter int PADDLE_H    = c_paddle_h,
    parameter int BALL_SZ     = c_ball_sz,
    parameter int PL_X        = c_pl_x,
    parameter int PR_X        = c_pr_x,
    parameter int PADDLE_VEL  = c_paddle_vel,
    parameter int BALL_VEL    = c_ball_vel,
    parameter int WIN_SCORE   = c_win_score,
    parameter int SERVE_TICKS = c_serve_ticks
) (
    input  logic        slowclock,
    input  logic        iRST_n,
    input  logic        pL_moveup,
    input  logic        pL_movedown,
    input  logic        pR_moveup,
    input  logic        pR_movedown,
    input  logic        start_n,
    output logic [31:0] ball,
    output logic [11:0] pL_ypos,
    output logic [11:0] pR_ypos,
    output logic [3:0]  scoreL,
    output logic [3:0]  scoreR,
    output logic [1:0]  game_state
);

    localparam int c_cnt_w = $clog2(SERVE_TICKS + 1);

    localparam coord_t  c_ctr_x      = coord_t'((SCREEN_W - BALL_SZ) / 2);
    localparam coord_t  c_ctr_y      = coord_t'((SCREEN_H - BALL_SZ) / 2);
    localparam coord_t  c_left_rest  = coord_t'(PL_X + PADDLE_W);
    localparam coord_t  c_right_rest = coord_t'(PR_X - BALL_SZ);
    localparam coord_t  c_floor_y    = coord_t'(SCREEN_H - BALL_SZ);
    localparam scoord_t c_bvel       = scoord_t'(BALL_VEL);
    localparam scoord_t c_ball_s     = scoord_t'(BALL_SZ);
    localparam scoord_t c_pad_h_s    = scoord_t'(PADDLE_H);
    localparam scoord_t c_left_face  = scoord_t'(PL_X + PADDLE_W);
    localparam scoord_t c_right_face = scoord_t'(PR_X);
    localparam scoord_t c_x_max      = scoord_t'(SCREEN_W - BALL_SZ);
    localparam scoord_t c_y_max      = scoord_t'(SCREEN_H - BALL_SZ);
    localparam scoord_t c_zero       = 13'sd0;
    localparam logic [3:0]         c_win        = 4'(WIN_SCORE);
    localparam logic [c_cnt_w-1:0] c_serve_last = c_cnt_w'(SERVE_TICKS - 1);

    logic [1:0]         state_d,      state_q;
    coord_t             x_d,          x_q;
    coord_t             y_d,          y_q;
    logic               dx_d,         dx_q;
    logic               dy_d,         dy_q;
    logic               serve_dir_d,  serve_dir_q;
    logic [3:0]         score_l_d,    score_l_q;
    logic [3:0]         score_r_d,    score_r_q;
    logic [c_cnt_w-1:0] serve_cnt_d,  serve_cnt_q;
    logic               start_prev_d, start_prev_q;

    logic    w_start_evt;
    logic    w_paddle_en;
    scoord_t w_x_s, w_y_s, w_nx, w_ny, w_pl_s, w_pr_s;
    logic    w_left_hit, w_right_hit;
    logic    w_miss_left, w_miss_right;

    assign w_start_evt = start_prev_q && !start_n;
    assign w_paddle_en = (state_q == c_st_serve) || (state_q == c_st_play);

    pong_paddle_mover #(
        .SCREEN_H   (SCREEN_H),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_VEL (PADDLE_VEL)
    ) u_paddle_l (
        .slowclock    (slowclock),
        .iRST_n       (iRST_n),
        .i_enable     (w_paddle_en),
        .i_moveup_n   (pL_moveup),
        .i_movedown_n (pL_movedown),
        .o_ypos       (pL_ypos)
    );

    pong_paddle_mover #(
        .SCREEN_H   (SCREEN_H),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_VEL (PADDLE_VEL)
    ) u_paddle_r (
        .slowclock    (slowclock),
        .iRST_n       (iRST_n),
        .i_enable     (w_paddle_en),
        .i_moveup_n   (pR_moveup),
        .i_movedown_n (pR_movedown),
        .o_ypos       (pR_ypos)
    );

    // Hit tests use the ball row and paddle rows from before this tick's move
    always_comb begin
        w_x_s  = scoord_t'({2'b00, x_q});
        w_y_s  = scoord_t'({2'b00, y_q});
        w_pl_s = scoord_t'({1'b0, pL_ypos});
        w_pr_s = scoord_t'({1'b0, pR_ypos});
        w_nx   = w_x_s + (dx_q ? c_bvel : -c_bvel);
        w_ny   = w_y_s + (dy_q ? c_bvel : -c_bvel);

        w_left_hit  = !dx_q && (w_x_s >= c_left_face) && (w_nx <= c_left_face)
                      && (w_y_s + c_ball_s > w_pl_s) && (w_y_s < w_pl_s + c_pad_h_s);
        w_right_hit = dx_q && (w_x_s + c_ball_s <= c_right_face)
                      && (w_nx + c_ball_s >= c_right_face)
                      && (w_y_s + c_ball_s > w_pr_s) && (w_y_s < w_pr_s + c_pad_h_s);
        w_miss_left  = (w_nx <= c_zero);
        w_miss_right = (w_nx >= c_x_max);
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        serve_dir_d  = serve_dir_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        serve_cnt_d  = serve_cnt_q;
        start_prev_d = start_n;

        case (state_q)
            c_st_idle: begin
                x_d       = c_ctr_x;
                y_d       = c_ctr_y;
                score_l_d = '0;
                score_r_d = '0;
                if (w_start_evt) begin
                    state_d     = c_st_serve;
                    serve_cnt_d = '0;
                end
            end
            c_st_serve: begin
                x_d         = c_ctr_x;
                y_d         = c_ctr_y;
                serve_cnt_d = serve_cnt_q + 1'b1;
                if (serve_cnt_q == c_serve_last) begin
                    state_d     = c_st_play;
                    dx_d        = serve_dir_q;
                    dy_d        = 1'b1;
                    serve_cnt_d = '0;
                end
            end
            c_st_play: begin
                if (w_ny <= c_zero) begin
                    y_d  = '0;
                    dy_d = 1'b1;
                end else if (w_ny >= c_y_max) begin
                    y_d  = c_floor_y;
                    dy_d = 1'b0;
                end else begin
                    y_d = w_ny[10:0];
                end

                // Paddle contact outranks the edge miss; a miss overrides the wall result
                if (w_left_hit) begin
                    x_d  = c_left_rest;
                    dx_d = 1'b1;
                end else if (w_right_hit) begin
                    x_d  = c_right_rest;
                    dx_d = 1'b0;
                end else if (w_miss_left || w_miss_right) begin
                    x_d         = c_ctr_x;
                    y_d         = c_ctr_y;
                    serve_cnt_d = '0;
                    if (w_miss_left) begin
                        score_r_d   = score_r_q + 4'd1;
                        serve_dir_d = 1'b0;
                    end else begin
                        score_l_d   = score_l_q + 4'd1;
                        serve_dir_d = 1'b1;
                    end
                    state_d = ((score_l_d == c_win) || (score_r_d == c_win))
                              ? c_st_gameover : c_st_serve;
                end else begin
                    x_d = w_nx[10:0];
                end
            end
            default: begin
                if (w_start_evt) begin
                    state_d   = c_st_idle;
                    score_l_d = '0;
                    score_r_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge slowclock or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= c_st_idle;
            x_q          <= c_ctr_x;
            y_q          <= c_ctr_y;
            dx_q         <= 1'b1;
            dy_q         <= 1'b1;
            serve_dir_q  <= 1'b1;
            score_l_q    <= '0;
            score_r_q    <= '0;
            serve_cnt_q  <= '0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            serve_dir_q  <= serve_dir_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            serve_cnt_q  <= serve_cnt_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign ball[c_ball_x_msb:c_ball_x_lsb] = x_q;
    assign ball[c_ball_y_msb:c_ball_y_lsb] = y_q;
    assign ball[c_ball_y_lsb-1:0]          = '0;
    assign scoreL     = score_l_q;
    assign scoreR     = score_r_q;
    assign game_state = state_q;

endmodule : pong_game_ctrl
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pong_game_ctrl
//  Description : Directed and randomized stimulus for pong_game_ctrl checked
//                against an integer game model.
//  Revision    : 1.0
// ============================================================================
module tb_pong_game_ctrl;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int PADDLE_W    = 20;
    localparam int PADDLE_H    = 100;
    localparam int BALL_SZ     = 20;
    localparam int PL_X        = 100;
    localparam int PR_X        = 500;
    localparam int PADDLE_VEL  = 10;
    localparam int BALL_VEL    = 3;
    localparam int WIN_SCORE   = 7;
    localparam int SERVE_TICKS = 32;

    logic        slowclock = 1'b0;
    logic        iRST_n;
    logic        pL_moveup, pL_movedown, pR_moveup, pR_movedown, start_n;
    logic [31:0] ball;
    logic [11:0] pL_ypos, pR_ypos;
    logic [3:0]  scoreL, scoreR;
    logic [1:0]  game_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: st 0..3 = idle/serve/play/gameover, directions are +1/-1
    int   m_st, m_x, m_y, m_dx, m_dy, m_sdir, m_sl, m_sr, m_cnt, m_pl, m_pr;
    logic m_prev;

    pong_game_ctrl #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .PADDLE_W(PADDLE_W),
        .PADDLE_H(PADDLE_H), .BALL_SZ(BALL_SZ), .PL_X(PL_X), .PR_X(PR_X),
        .PADDLE_VEL(PADDLE_VEL), .BALL_VEL(BALL_VEL), .WIN_SCORE(WIN_SCORE),
        .SERVE_TICKS(SERVE_TICKS)
    ) dut (
        .slowclock  (slowclock),
        .iRST_n     (iRST_n),
        .pL_moveup  (pL_moveup),
        .pL_movedown(pL_movedown),
        .pR_moveup  (pR_moveup),
        .pR_movedown(pR_movedown),
        .start_n    (start_n),
        .ball       (ball),
        .pL_ypos    (pL_ypos),
        .pR_ypos    (pR_ypos),
        .scoreL     (scoreL),
        .scoreR     (scoreR),
        .game_state (game_state)
    );

    always #5 slowclock = ~slowclock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                     tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic int paddle_next(input int p, input logic up_n, input logic dn_n);
        int n;
        n = p;
        if (!up_n && dn_n)      n = p - PADDLE_VEL;
        else if (up_n && !dn_n) n = p + PADDLE_VEL;
        if (n < 0)                 n = 0;
        if (n > SCREEN_H - PADDLE_H) n = SCREEN_H - PADDLE_H;
        return n;
    endfunction

    task automatic model_reset();
        m_st = 0; m_x = (SCREEN_W - BALL_SZ) / 2; m_y = (SCREEN_H - BALL_SZ) / 2;
        m_dx = 1; m_dy = 1; m_sdir = 1; m_sl = 0; m_sr = 0; m_cnt = 0;
        m_pl = (SCREEN_H - PADDLE_H) / 2; m_pr = m_pl; m_prev = 1'b1;
    endtask

    task automatic model_step(input logic lu, input logic ld, input logic ru,
                              input logic rd, input logic sn);
        int  nx, ny, old_st;
        bit  ev, lhit, rhit;
        ev     = m_prev && !sn;
        m_prev = sn;
        old_st = m_st;
        case (m_st)
            0: begin
                m_x = (SCREEN_W - BALL_SZ) / 2; m_y = (SCREEN_H - BALL_SZ) / 2;
                m_sl = 0; m_sr = 0;
                if (ev) begin m_st = 1; m_cnt = 0; end
            end
            1: begin
                m_x = (SCREEN_W - BALL_SZ) / 2; m_y = (SCREEN_H - BALL_SZ) / 2;
                if (m_cnt == SERVE_TICKS - 1) begin
                    m_st = 2; m_dx = m_sdir; m_dy = 1; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            2: begin
                nx   = m_x + m_dx * BALL_VEL;
                ny   = m_y + m_dy * BALL_VEL;
                lhit = (m_dx < 0) && (m_x >= PL_X + PADDLE_W) && (nx <= PL_X + PADDLE_W)
                       && (m_y + BALL_SZ > m_pl) && (m_y < m_pl + PADDLE_H);
                rhit = (m_dx > 0) && (m_x + BALL_SZ <= PR_X) && (nx + BALL_SZ >= PR_X)
                       && (m_y + BALL_SZ > m_pr) && (m_y < m_pr + PADDLE_H);
                if (ny <= 0)                          begin m_y = 0; m_dy = 1; end
                else if (ny >= SCREEN_H - BALL_SZ)    begin m_y = SCREEN_H - BALL_SZ; m_dy = -1; end
                else                                  m_y = ny;
                if (lhit)      begin m_x = PL_X + PADDLE_W; m_dx = 1; end
                else if (rhit) begin m_x = PR_X - BALL_SZ;  m_dx = -1; end
                else if (nx <= 0 || nx >= SCREEN_W - BALL_SZ) begin
                    if (nx <= 0) begin m_sr++; m_sdir = -1; end
                    else         begin m_sl++; m_sdir = 1;  end
                    m_x = (SCREEN_W - BALL_SZ) / 2; m_y = (SCREEN_H - BALL_SZ) / 2;
                    m_cnt = 0;
                    m_st  = (m_sl == WIN_SCORE || m_sr == WIN_SCORE) ? 3 : 1;
                end else begin
                    m_x = nx;
                end
            end
            default: begin
                if (ev) begin m_st = 0; m_sl = 0; m_sr = 0; end
            end
        endcase
        if (old_st == 1 || old_st == 2) begin
            m_pl = paddle_next(m_pl, lu, ld);
            m_pr = paddle_next(m_pr, ru, rd);
        end
    endtask

    task automatic compare_all();
        logic [10:0] ex, ey;
        ex = 11'(m_x);
        ey = 11'(m_y);
        check_eq("game_state", {30'd0, game_state}, 32'(m_st));
        check_eq("ball",       ball,                {ex, ey, 10'd0});
        check_eq("pL_ypos",    {20'd0, pL_ypos},    32'(m_pl));
        check_eq("pR_ypos",    {20'd0, pR_ypos},    32'(m_pr));
        check_eq("scoreL",     {28'd0, scoreL},     32'(m_sl));
        check_eq("scoreR",     {28'd0, scoreR},     32'(m_sr));
    endtask

    // Called at a falling edge: drive, let the rising edge happen, check at next fall
    task automatic tick(input logic lu, input logic ld, input logic ru,
                        input logic rd, input logic sn);
        pL_moveup = lu; pL_movedown = ld; pR_moveup = ru; pR_movedown = rd; start_n = sn;
        @(posedge slowclock);
        model_step(lu, ld, ru, rd, sn);
        @(negedge slowclock);
        compare_all();
    endtask

    initial begin
        int guard;
        logic [31:0] r;
        iRST_n = 1'b0;
        pL_moveup = 1'b1; pL_movedown = 1'b1; pR_moveup = 1'b1; pR_movedown = 1'b1;
        start_n = 1'b1;
        model_reset();
        repeat (3) @(negedge slowclock);
        compare_all();
        iRST_n = 1'b1;

        // Start, serve window with paddle driving, first play tick
        tick(1, 1, 1, 1, 1);
        tick(1, 1, 1, 1, 0);
        check_eq("enter_serve", {30'd0, game_state}, 32'd1);
        tick(0, 1, 0, 0, 0);
        for (int i = 1; i < 4; i++) tick(0, 1, 0, 0, 1);
        check_eq("both_low_hold", {20'd0, pR_ypos}, 32'd190);
        for (int i = 4; i < SERVE_TICKS; i++) tick(0, 1, 1, 0, 1);
        check_eq("serve_to_play", {30'd0, game_state}, 32'd2);
        check_eq("pL_top_sat",    {20'd0, pL_ypos},    32'd0);
        check_eq("pR_bot_sat",    {20'd0, pR_ypos},    32'd380);
        tick(1, 1, 1, 1, 1);
        check_eq("first_x", {21'd0, ball[31:21]}, 32'd313);
        check_eq("first_y", {21'd0, ball[20:10]}, 32'd233);

        for (int i = 0; i < 56; i++) tick(1, 1, 1, 1, 1);
        check_eq("hit_x",      {21'd0, ball[31:21]}, 32'd480);
        check_eq("hit_scoreL", {28'd0, scoreL},      32'd0);
        tick(1, 1, 1, 1, 1);
        check_eq("hit_dx_flip", {21'd0, ball[31:21]}, 32'd477);

        // Asynchronous reset landing between edges in play
        iRST_n = 1'b0;
        #3;
        model_reset();
        compare_all();
        @(negedge slowclock);
        iRST_n = 1'b1;
        tick(1, 1, 1, 1, 1);

        for (int i = 0; i < 4000; i++) begin
            r = $urandom;
            tick(r[0], r[1], r[2], r[3], (r[7:4] == 4'd0) ? 1'b0 : 1'b1);
        end

        // Another mid-play reset once play is reached
        guard = 0;
        while (m_st != 2 && guard < 600) begin
            r = $urandom;
            tick(r[0], r[1], r[2], r[3], (r[6:4] == 3'd0) ? 1'b0 : 1'b1);
            guard++;
        end
        check_eq("reach_play", 32'(m_st), 32'd2);
        for (int i = 0; i < 5; i++) tick(1, 1, 1, 1, 1);
        #2 iRST_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge slowclock);
        iRST_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            tick(r[0], r[1], r[2], r[3], (r[7:4] == 4'd0) ? 1'b0 : 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pong_game_ctrl
`default_nettype wire
